// File: rtl/sfx_pkg.sv
// Shared types and helpers for the sound-effect scheduler: effect ids, FSM states,
// the pending-request priority encoder and counter widths.
package sfx_pkg;

   localparam int HP_W  = 16;
   localparam int DUR_W = 8;

   typedef enum logic [1:0] {
      SFX_NONE  = 2'd0,
      SFX_FLAP  = 2'd1,
      SFX_SCORE = 2'd2,
      SFX_CRASH = 2'd3
   } sfx_id_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FLAP    = 3'd1,
      ST_SCORE_A = 3'd2,
      ST_SCORE_B = 3'd3,
      ST_CRASH   = 3'd4
   } sfx_state_t;

   // Crash outranks score, score outranks flap.
   function automatic sfx_id_t prio_enc(input logic [2:0] pend);
      if (pend[2])      return SFX_CRASH;
      else if (pend[1]) return SFX_SCORE;
      else if (pend[0]) return SFX_FLAP;
      else              return SFX_NONE;
   endfunction

   function automatic sfx_id_t state_id(input sfx_state_t s);
      case (s)
         ST_FLAP:    return SFX_FLAP;
         ST_SCORE_A: return SFX_SCORE;
         ST_SCORE_B: return SFX_SCORE;
         ST_CRASH:   return SFX_CRASH;
         default:    return SFX_NONE;
      endcase
   endfunction

   function automatic logic [2:0] id_mask(input sfx_id_t id);
      case (id)
         SFX_FLAP:  return 3'b001;
         SFX_SCORE: return 3'b010;
         SFX_CRASH: return 3'b100;
         default:   return 3'b000;
      endcase
   endfunction

   function automatic logic [DUR_W-1:0] dur_fix(input logic [DUR_W-1:0] d);
      return (d == '0) ? DUR_W'(1) : d;
   endfunction

endpackage

// File: rtl/sfx_tone.sv
// Square-wave generator: counts clk cycles and flips the phase every hp cycles.
// An hp of 0 behaves like 1 (toggle every cycle).
module sfx_tone
   import sfx_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic            en,
   input  logic [HP_W-1:0] hp,
   output logic            phase
);

   logic [HP_W-1:0] cnt;
   logic [HP_W-1:0] hp_last;

   assign hp_last = (hp == '0) ? '0 : hp - HP_W'(1);

   // The >= compare lets a shrinking or swept hp wrap on the very next cycle.
   always_ff @(posedge clk) begin
      if (reset || load) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (en) begin
         if (cnt >= hp_last) begin
            cnt   <= '0;
            phase <= ~phase;
         end else begin
            cnt <= cnt + HP_W'(1);
         end
      end
   end

endmodule

// File: rtl/sfx_scheduler.sv
// Arbitrates the 1-bit speaker between flap, score and crash effects: pending latch,
// priority/preemption FSM, ms tick divider and the crash half-period sweep.
module sfx_scheduler
   import sfx_pkg::*;
#(
   parameter int               TICK_DIV       = 25000,
   parameter logic [HP_W-1:0]  HP_FLAP        = 16'd12500,
   parameter logic [DUR_W-1:0] DUR_FLAP       = 8'd60,
   parameter logic [HP_W-1:0]  HP_SCORE_A     = 16'd6250,
   parameter logic [DUR_W-1:0] DUR_SCORE_A    = 8'd80,
   parameter logic [HP_W-1:0]  HP_SCORE_B     = 16'd4700,
   parameter logic [DUR_W-1:0] DUR_SCORE_B    = 8'd120,
   parameter logic [HP_W-1:0]  HP_CRASH_START = 16'd8000,
   parameter logic [HP_W-1:0]  CRASH_STEP     = 16'd40,
   parameter logic [DUR_W-1:0] DUR_CRASH      = 8'd250
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] req,
   input  logic       mute,
   output logic       speaker,
   output logic       busy,
   output logic [1:0] active_id
);

   localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   sfx_state_t       state, state_n;
   logic [2:0]       pend, pend_n;
   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   logic [HP_W-1:0]  hp_q, hp_n;
   logic [DUR_W-1:0] dur_q, dur_n;
   logic [HP_W:0]    sweep_sum;
   logic [HP_W-1:0]  hp_sweep;
   sfx_id_t          cur_id, top_id, start_id;
   logic             start, tone_load, phase;

   assign tick      = (div_cnt == DIV_W'(TICK_DIV - 1));
   assign sweep_sum = {1'b0, hp_q} + {1'b0, CRASH_STEP};
   assign hp_sweep  = sweep_sum[HP_W] ? '1 : sweep_sum[HP_W-1:0];
   assign cur_id    = state_id(state);
   assign top_id    = prio_enc(pend);

   always_comb begin
      state_n   = state;
      hp_n      = hp_q;
      dur_n     = dur_q;
      start     = 1'b0;
      start_id  = SFX_NONE;
      tone_load = 1'b0;

      if (state == ST_IDLE) begin
         if (top_id != SFX_NONE) begin
            start    = 1'b1;
            start_id = top_id;
         end
      end else if (top_id > cur_id) begin
         start    = 1'b1;
         start_id = top_id;
      end else if ((pend & id_mask(cur_id)) != 3'b000) begin
         start    = 1'b1;
         start_id = cur_id;
      end else if (tick) begin
         if (dur_q <= DUR_W'(1)) begin
            tone_load = 1'b1;
            if (state == ST_SCORE_A) begin
               state_n = ST_SCORE_B;
               hp_n    = HP_SCORE_B;
               dur_n   = dur_fix(DUR_SCORE_B);
            end else begin
               state_n = ST_IDLE;
            end
         end else begin
            dur_n = dur_q - DUR_W'(1);
            if (state == ST_CRASH) hp_n = hp_sweep;
         end
      end

      // Any start (fresh, preempting or retriggering) begins from the effect's first phase.
      if (start) begin
         tone_load = 1'b1;
         case (start_id)
            SFX_FLAP: begin
               state_n = ST_FLAP;
               hp_n    = HP_FLAP;
               dur_n   = dur_fix(DUR_FLAP);
            end
            SFX_SCORE: begin
               state_n = ST_SCORE_A;
               hp_n    = HP_SCORE_A;
               dur_n   = dur_fix(DUR_SCORE_A);
            end
            SFX_CRASH: begin
               state_n = ST_CRASH;
               hp_n    = HP_CRASH_START;
               dur_n   = dur_fix(DUR_CRASH);
            end
            default: ;
         endcase
      end

      // A request arriving in the same cycle as the clear keeps its bit set.
      pend_n = (pend & ~(start ? id_mask(start_id) : 3'b000)) | req;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         pend    <= '0;
         div_cnt <= '0;
         hp_q    <= '0;
         dur_q   <= '0;
         speaker <= 1'b0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
         state   <= state_n;
         pend    <= pend_n;
         hp_q    <= hp_n;
         dur_q   <= dur_n;
         speaker <= phase & ~mute;
      end
   end

   assign busy      = (state != ST_IDLE);
   assign active_id = cur_id;

   sfx_tone u_tone (
      .clk   (clk),
      .reset (reset),
      .load  (tone_load),
      .en    (busy),
      .hp    (hp_q),
      .phase (phase)
   );

endmodule
